// File: rtl/div_arb_pkg.sv
// Shared definitions for the divider arbiter.
//   state_t     : arbiter FSM encoding (IDLE, LAUNCH, WAIT, RESP)
//   DIV_ZERO_Q  : quotient reported for a zero divisor (all ones, sliced to WIDTH)
//   nextIdx     : round-robin pointer advance, modulo the requester count
package div_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  // Wide enough for any supported WIDTH; users take the low WIDTH bits.
  localparam logic [63:0] DIV_ZERO_Q = '1;

  function automatic int nextIdx(input int idx, input int n);
    return (idx + 1) % n;
  endfunction

endpackage

// File: rtl/div_arbiter_if.sv
// Link between the arbiter and the shared divider.
//   div_start      : one-cycle start pulse (arbiter -> divider)
//   div_a, div_b   : dividend / divisor, held from div_start until div_fin
//   div_fin        : completion pulse (divider -> arbiter)
//   div_q, div_r   : quotient / remainder, valid with div_fin
// master = arbiter side, slave = divider side.
interface div_arbiter_if #(
  parameter int WIDTH = 8
) ();

  logic             div_start;
  logic [WIDTH-1:0] div_a;
  logic [WIDTH-1:0] div_b;
  logic             div_fin;
  logic [WIDTH-1:0] div_q;
  logic [WIDTH-1:0] div_r;

  modport master (
    output div_start, div_a, div_b,
    input  div_fin, div_q, div_r
  );

  modport slave (
    input  div_start, div_a, div_b,
    output div_fin, div_q, div_r
  );

endinterface

// File: rtl/div_arb_rr_pick.sv
// Combinational round-robin selector.
//   req   : request vector
//   ptr   : highest-priority index for this pick
//   grant : one-hot winner (first set bit at or cyclically after ptr)
//   idx   : binary index of the winner
//   any   : at least one request present
module div_arb_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDXW    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDXW-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDXW-1:0]    idx,
  output logic               any
);

  logic [IDXW-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IDXW'((int'(ptr) + k) % NUM_REQ);
      if (!any && req[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/div_arbiter.sv
// Round-robin arbiter sharing one multi-cycle divider among NUM_REQ requesters.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   req           : per-requester request level
//   a_in, b_in    : packed dividends / divisors, slice i for requester i
//   gnt           : one-hot grant, held from grant until completion
//   done          : one-cycle completion pulse to the served requester
//   q_out, r_out  : quotient / remainder, held between done pulses
//   err           : divide-by-zero (or timeout) flag, valid with done
//   busy          : high whenever the FSM is not IDLE
//   div           : divider link (div_arbiter_if.master)
// Optional feature: define DIV_ARB_TIMEOUT_EN to abort a WAIT that lasts
// TIMEOUT cycles without div_fin (result q=0, r=0, err=1).
module div_arbiter
  import div_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] a_in,
  input  logic [NUM_REQ*WIDTH-1:0] b_in,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [NUM_REQ-1:0]       done,
  output logic [WIDTH-1:0]         q_out,
  output logic [WIDTH-1:0]         r_out,
  output logic                     err,
  output logic                     busy,
  div_arbiter_if.master            div
);

  localparam int IDXW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1) begin : gBadParam
    $error("div_arbiter: NUM_REQ must be 2..8 and TIMEOUT at least 1");
  end

  state_t           state;
  logic [IDXW-1:0]  ptr;
  logic [IDXW-1:0]  grantIdx;
  logic [WIDTH-1:0] capA, capB;
  // Result staged here so q_out/r_out/err only change together with done.
  logic [WIDTH-1:0] resQ, resR;
  logic             resErr;

  logic [NUM_REQ-1:0] pickGnt;
  logic [IDXW-1:0]    pickIdx;
  logic               pickAny;

`ifdef DIV_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] waitCnt;
`endif

  div_arb_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDXW    (IDXW)
  ) uPick (
    .req   (req),
    .ptr   (ptr),
    .grant (pickGnt),
    .idx   (pickIdx),
    .any   (pickAny)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      ptr           <= '0;
      grantIdx      <= '0;
      gnt           <= '0;
      done          <= '0;
      q_out         <= '0;
      r_out         <= '0;
      err           <= 1'b0;
      busy          <= 1'b0;
      capA          <= '0;
      capB          <= '0;
      resQ          <= '0;
      resR          <= '0;
      resErr        <= 1'b0;
      div.div_start <= 1'b0;
      div.div_a     <= '0;
      div.div_b     <= '0;
`ifdef DIV_ARB_TIMEOUT_EN
      waitCnt       <= '0;
`endif
    end else begin
      done          <= '0;
      div.div_start <= 1'b0;
      case (state)
        // Arbitrate and capture the winner's operands.
        IDLE: begin
          if (pickAny) begin
            gnt      <= pickGnt;
            grantIdx <= pickIdx;
            capA     <= a_in[int'(pickIdx)*WIDTH +: WIDTH];
            capB     <= b_in[int'(pickIdx)*WIDTH +: WIDTH];
            busy     <= 1'b1;
            state    <= LAUNCH;
          end
        end
        // Start the divider, or short-circuit a zero divisor.
        LAUNCH: begin
          if (capB != '0) begin
            div.div_start <= 1'b1;
            div.div_a     <= capA;
            div.div_b     <= capB;
`ifdef DIV_ARB_TIMEOUT_EN
            waitCnt       <= '0;
`endif
            state         <= WAIT;
          end else begin
            resQ   <= DIV_ZERO_Q[WIDTH-1:0];
            resR   <= capA;
            resErr <= 1'b1;
            state  <= RESP;
          end
        end
        // Wait for the divider result.
        WAIT: begin
          if (div.div_fin) begin
            resQ   <= div.div_q;
            resR   <= div.div_r;
            resErr <= 1'b0;
            state  <= RESP;
          end
`ifdef DIV_ARB_TIMEOUT_EN
          else if (waitCnt == CNT_W'(TIMEOUT - 1)) begin
            resQ   <= '0;
            resR   <= '0;
            resErr <= 1'b1;
            state  <= RESP;
          end else begin
            waitCnt <= waitCnt + 1'b1;
          end
`endif
        end
        // Deliver the result and hand priority to the next requester.
        RESP: begin
          done  <= gnt;
          q_out <= resQ;
          r_out <= resR;
          err   <= resErr;
          gnt   <= '0;
          ptr   <= IDXW'(nextIdx(int'(grantIdx), NUM_REQ));
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          gnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_arbiter.sv
// Directed self-checking bench for div_arbiter; the bench plays the divider.
module tb_div_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req;
  logic [N*W-1:0]   a_in;
  logic [N*W-1:0]   b_in;
  logic [N-1:0]     gnt;
  logic [N-1:0]     done;
  logic [W-1:0]     q_out;
  logic [W-1:0]     r_out;
  logic             err;
  logic             busy;

  int nChecks = 0;
  int nFail   = 0;

  div_arbiter_if #(.WIDTH(W)) dif ();

  div_arbiter #(
    .NUM_REQ (N),
    .WIDTH   (W),
    .TIMEOUT (64)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .a_in  (a_in),
    .b_in  (b_in),
    .gnt   (gnt),
    .done  (done),
    .q_out (q_out),
    .r_out (r_out),
    .err   (err),
    .busy  (busy),
    .div   (dif)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setOp(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    a_in[i*W +: W] = a;
    b_in[i*W +: W] = b;
  endtask

  task automatic pulseFin(input logic [W-1:0] q, input logic [W-1:0] r);
    dif.div_fin = 1'b1;
    dif.div_q   = q;
    dif.div_r   = r;
    tick();
    dif.div_fin = 1'b0;
  endtask

  task automatic waitGnt(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (gnt != '0) ok = 1'b1;
      else tick();
    end
  endtask

  task automatic waitStart(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (dif.div_start) ok = 1'b1;
      else tick();
    end
  endtask

  task automatic waitDone(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (done != '0) ok = 1'b1;
      else tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; a_in = '0; b_in = '0;
    dif.div_fin = 1'b0; dif.div_q = '0; dif.div_r = '0;
    tick(); tick(); tick();
    nChecks++;
    if ({gnt, done, busy, err} !== '0) begin
      nFail++;
      $display("FAIL reset_ctrl: gnt=%b done=%b busy=%b err=%b required all 0", gnt, done, busy, err);
    end
    nChecks++;
    if ({q_out, r_out, dif.div_start, dif.div_a, dif.div_b} !== '0) begin
      nFail++;
      $display("FAIL reset_data: q=%0d r=%0d start=%b a=%0d b=%0d required all 0",
               q_out, r_out, dif.div_start, dif.div_a, dif.div_b);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_fairness();
    bit ok;
    int exp;
    logic [N-1:0] expOh;
    for (int i = 0; i < N; i++) setOp(i, W'(50 + 11*i), W'(5 + i));
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp   = k % N;
      expOh = N'(1 << exp);
      waitGnt(ok);
      nChecks++;
      if (!ok || gnt !== expOh) begin
        nFail++;
        $display("FAIL fair_gnt[%0d]: got %b required %b", k, gnt, expOh);
      end
      if (k == 4) req = '0;
      waitStart(ok);
      nChecks++;
      if (!ok || dif.div_a !== W'(50 + 11*exp) || dif.div_b !== W'(5 + exp)) begin
        nFail++;
        $display("FAIL fair_operands[%0d]: a=%0d b=%0d required %0d/%0d", k,
                 dif.div_a, dif.div_b, 50 + 11*exp, 5 + exp);
      end
      tick();
      pulseFin(W'(10), W'(exp));
      waitDone(ok);
      nChecks++;
      if (!ok || done !== expOh || q_out !== W'(10) || r_out !== W'(exp) || err !== 1'b0) begin
        nFail++;
        $display("FAIL fair_done[%0d]: done=%b q=%0d r=%0d err=%b required %b/10/%0d/0",
                 k, done, q_out, r_out, err, expOh, exp);
      end
    end
    tick();
  endtask

  task automatic test_single();
    bit ok;
    setOp(0, W'(100), W'(7));
    req = 4'b0001;
    tick();
    nChecks++;
    if (gnt !== 4'b0001 || busy !== 1'b1) begin
      nFail++;
      $display("FAIL single_gnt: gnt=%b busy=%b required 0001/1", gnt, busy);
    end
    req = '0;
    tick();
    nChecks++;
    if (dif.div_start !== 1'b1 || dif.div_a !== W'(100) || dif.div_b !== W'(7)) begin
      nFail++;
      $display("FAIL single_start: start=%b a=%0d b=%0d required 1/100/7",
               dif.div_start, dif.div_a, dif.div_b);
    end
    tick();
    nChecks++;
    if (dif.div_start !== 1'b0 || dif.div_a !== W'(100) || dif.div_b !== W'(7)) begin
      nFail++;
      $display("FAIL single_start_pulse: start=%b a=%0d b=%0d required 0/100/7",
               dif.div_start, dif.div_a, dif.div_b);
    end
    pulseFin(W'(14), W'(2));
    waitDone(ok);
    nChecks++;
    if (!ok || done !== 4'b0001 || q_out !== W'(14) || r_out !== W'(2) || err !== 1'b0) begin
      nFail++;
      $display("FAIL single_done: done=%b q=%0d r=%0d err=%b required 0001/14/2/0",
               done, q_out, r_out, err);
    end
    tick();
    nChecks++;
    if (done !== 4'b0000 || q_out !== W'(14) || r_out !== W'(2)) begin
      nFail++;
      $display("FAIL single_hold: done=%b q=%0d r=%0d required 0000/14/2", done, q_out, r_out);
    end
  endtask

  task automatic test_div_zero();
    logic sawStart;
    setOp(2, W'(55), W'(0));
    req = 4'b0100;
    tick();
    sawStart = dif.div_start;
    nChecks++;
    if (gnt !== 4'b0100) begin
      nFail++;
      $display("FAIL dz_gnt: got %b required 0100", gnt);
    end
    req = '0;
    tick();
    sawStart |= dif.div_start;
    nChecks++;
    if (done !== 4'b0000) begin
      nFail++;
      $display("FAIL dz_early_done: got %b required 0000", done);
    end
    tick();
    sawStart |= dif.div_start;
    nChecks++;
    if (done !== 4'b0100 || q_out !== W'(255) || r_out !== W'(55) || err !== 1'b1) begin
      nFail++;
      $display("FAIL dz_done: done=%b q=%0d r=%0d err=%b required 0100/255/55/1",
               done, q_out, r_out, err);
    end
    tick();
    sawStart |= dif.div_start;
    nChecks++;
    if (sawStart !== 1'b0 || done !== 4'b0000) begin
      nFail++;
      $display("FAIL dz_no_start: start_seen=%b done=%b required 0/0000", sawStart, done);
    end
  endtask

  task automatic test_drop();
    bit ok;
    setOp(1, W'(9), W'(2));
    req = 4'b0010;
    tick();
    waitStart(ok);
    req = '0;
    tick();
    tick();
    nChecks++;
    if (!ok || gnt !== 4'b0010 || busy !== 1'b1) begin
      nFail++;
      $display("FAIL drop_wait: gnt=%b busy=%b required 0010/1", gnt, busy);
    end
    pulseFin(W'(4), W'(1));
    waitDone(ok);
    nChecks++;
    if (!ok || done !== 4'b0010 || q_out !== W'(4) || r_out !== W'(1) || err !== 1'b0) begin
      nFail++;
      $display("FAIL drop_done: done=%b q=%0d r=%0d err=%b required 0010/4/1/0",
               done, q_out, r_out, err);
    end
    tick();
    pulseFin(W'(99), W'(99));
    tick();
    tick();
    nChecks++;
    if (done !== 4'b0000 || busy !== 1'b0 || gnt !== 4'b0000 || q_out !== W'(4)) begin
      nFail++;
      $display("FAIL idle_fin_ignored: done=%b busy=%b gnt=%b q=%0d required 0000/0/0000/4",
               done, busy, gnt, q_out);
    end
  endtask

  task automatic test_rst_mid();
    bit ok;
    logic sawDone;
    setOp(2, W'(20), W'(3));
    req = 4'b0100;
    tick();
    waitStart(ok);
    req = '0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    nChecks++;
    if (!ok || {busy, gnt, done, dif.div_start, q_out, err} !== '0) begin
      nFail++;
      $display("FAIL rst_mid_state: busy=%b gnt=%b done=%b start=%b q=%0d err=%b required all 0",
               busy, gnt, done, dif.div_start, q_out, err);
    end
    pulseFin(W'(6), W'(2));
    sawDone = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sawDone |= |done;
      tick();
    end
    nChecks++;
    if (sawDone !== 1'b0 || busy !== 1'b0) begin
      nFail++;
      $display("FAIL rst_mid_late_fin: done_seen=%b busy=%b required 0/0", sawDone, busy);
    end
    req = 4'b1111;
    tick();
    nChecks++;
    if (gnt !== 4'b0001) begin
      nFail++;
      $display("FAIL rst_mid_ptr: gnt=%b required 0001", gnt);
    end
    req = '0;
    waitStart(ok);
    tick();
    pulseFin(W'(14), W'(2));
    waitDone(ok);
    nChecks++;
    if (!ok || done !== 4'b0001 || q_out !== W'(14)) begin
      nFail++;
      $display("FAIL rst_mid_recover: done=%b q=%0d required 0001/14", done, q_out);
    end
    tick();
  endtask

`ifdef DIV_ARB_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    int n;
    setOp(0, W'(7), W'(1));
    req = 4'b0001;
    tick();
    req = '0;
    waitStart(ok);
    n = 0;
    while (done == '0 && n < 200) begin
      tick();
      n++;
    end
    nChecks++;
    if (!ok || n != 65 || done !== 4'b0001 || err !== 1'b1 || q_out !== '0 || r_out !== '0) begin
      nFail++;
      $display("FAIL timeout_done: cycles=%0d done=%b err=%b q=%0d r=%0d required 65/0001/1/0/0",
               n, done, err, q_out, r_out);
    end
    tick();
    pulseFin(W'(7), W'(0));
    tick();
    nChecks++;
    if (done !== 4'b0000 || busy !== 1'b0 || q_out !== '0) begin
      nFail++;
      $display("FAIL timeout_late_fin: done=%b busy=%b q=%0d required 0000/0/0", done, busy, q_out);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_fairness();
    test_single();
    test_div_zero();
    test_drop();
    test_rst_mid();
`ifdef DIV_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
